delay_event_scheduler: RTL and testbench
========================================

# delay_event_scheduler

Hardware timed-event scheduler for the dynamic-scheduling test harness. Requesters post an event ID plus a relative delay in ticks; the block holds up to SLOTS pending events, counts each delay down, and releases expired events one per cycle on a ready/valid output. Among expired events it releases the oldest-accepted first, giving deterministic ordering for events that come due together. It sits between stimulus threads and the checker, sequencing which delayed action fires when.

## Interface
- SLOTS, 4: number of pending-event slots (2..16).
- DW, 8: delay width in ticks.
- IW, 4: event ID width.
- CW, $clog2(SLOTS+1): occupancy width (derived, not overridable).
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- tick  in  1  time-base enable; counters decrement only on cycles with tick=1.
- flush  in  1  synchronous clear of all slots.
- req_valid  in  1  request present.
- req_ready  out  1  a free slot exists.
- req_delay  in  DW  relative delay in ticks.
- req_id  in  IW  event ID.
- fire_valid  out  1  at least one slot expired.
- fire_ready  in  1  consumer accepts fired event.
- fire_id  out  IW  ID of the oldest expired slot.
- occupancy  out  CW  number of valid slots.

## Operation
- Slot state: valid, cnt[DW], id[IW]. Slot is expired when valid && cnt==0.
- Accept when req_valid && req_ready: load the lowest-index free slot with cnt=req_delay, id=req_id, valid=1.
- Countdown: each cycle with tick=1, every valid slot with cnt!=0 decrements by 1. Expired slots hold at 0; no underflow, no wrap.
- Age matrix older[i][j] (SLOTS x SLOTS): on accept into slot k, older[k][j]=valid[j] for all j≠k, and older[j][k]=0. Slot i is selected when it is expired and no expired j has older[i][j]=1.
- Fire when fire_valid && fire_ready: the selected slot's valid bit is cleared. At most one release per cycle.
- req_ready = any slot invalid, computed from registered state only; a slot freed by a fire in cycle t is not reusable until t+1.
- Simultaneous accept and fire in the same cycle both take effect (different slots by construction).
- flush: clears all valid bits and the age matrix on the next edge and overrides accept and fire in that cycle. With fire_valid=1, the fire handshake that is nominally visible is discarded.
- occupancy = popcount(valid).
- fire_id is don't-care when fire_valid=0 and is driven to 0.

## Timing
- Reset (async, rst_n=0): all valid=0, cnt=0, id=0, age matrix 0. Outputs: req_ready=1, fire_valid=0, fire_id=0, occupancy=0.
- fire_valid and fire_id are combinational from registered slot state only, with no path from fire_ready. req_ready has no path from req_valid.
- Latency with tick held at 1: a request accepted at edge E with delay d raises fire_valid in the cycle after edge E+d. For d=0 this is the cycle immediately after acceptance.
- With tick gated, the latency is d tick-cycles after acceptance, plus 1 cycle.
- Back-pressure: with fire_ready=0, expired slots persist indefinitely. Non-expired slots keep counting.
- Full: with occupancy==SLOTS, req_ready=0 and requests stall.

## Structure
- sched_pkg holds the slot_t struct (valid, cnt, id) and DW/IW defaults as localparams.
- Sub-module sched_slot is one countdown slot: load, tick, clear, and an expired flag.
- The top level holds the age matrix, free-slot priority encoder, oldest-expired selection, and occupancy counter.

## Test plan
- Reset mid-run: with 3 slots loaded, drop rst_n asynchronously → the same cycle shows fire_valid=0, occupancy=0, req_ready=1.
- Single event, tick=1: accept id=5, delay=3 at edge E → fire_valid=1 and fire_id=5 in the cycle after E+3. Pop it → occupancy returns to 0.
- Same-deadline ordering: accept id=1 d=4, then id=2 d=3 on the next cycle, with fire_ready=0 until both are expired. Then raise fire_ready → releases id=1 then id=2 on consecutive cycles.
- Full/stall: fill 4 slots with d=10 → req_ready=0 and a 5th request is held. After the first fire, req_ready=1 on the following cycle and the 5th request enters the freed slot.
- Tick gating: accept d=2 with tick pattern 1,0,0,1 → fire_valid rises only after the second tick. Delay 0 fires regardless of tick.
- Flush with fire handshake pending: 2 expired slots and fire_ready=1, assert flush → both slots cleared, no further fire_valid, occupancy=0.

Source files
------------

// File: rtl/delay_event_scheduler_pkg.sv
// Shared types for the delay event scheduler: default widths and the per-slot record.
package delay_event_scheduler_pkg;

    localparam int SCHED_SLOTS = 4;
    localparam int SCHED_DW    = 8;
    localparam int SCHED_IW    = 4;

    typedef struct packed {
        logic                valid;
        logic [SCHED_DW-1:0] cnt;
        logic [SCHED_IW-1:0] id;
    } slot_t;

endpackage

// File: rtl/delay_event_scheduler_if.sv
// Request and fire channels of the scheduler.
// Both channels use valid/ready: a transfer happens on a clock edge where valid && ready are both 1;
// valid never depends on ready and ready never depends on valid.
interface delay_event_scheduler_if #(
    parameter int DW = 8,
    parameter int IW = 4
) ();
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_delay;
    logic [IW-1:0] req_id;
    logic          fire_valid;
    logic          fire_ready;
    logic [IW-1:0] fire_id;

    modport master (
        output req_valid, req_delay, req_id, fire_ready,
        input  req_ready, fire_valid, fire_id
    );

    modport slave (
        input  req_valid, req_delay, req_id, fire_ready,
        output req_ready, fire_valid, fire_id
    );
endinterface

// File: rtl/delay_event_scheduler_slot.sv
// One pending-event slot: loads a delay and ID, counts down on tick, flags expiry at zero.
module delay_event_scheduler_slot
    import delay_event_scheduler_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  tick,
    input  logic  load,
    input  logic  clear,
    input  slot_t load_val,
    output slot_t state,
    output logic  expired
);

    // clear wins over load; the top never asserts both for the same slot outside a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
        end else if (clear) begin
            state.valid <= 1'b0;
        end else if (load) begin
            state       <= load_val;
            state.valid <= 1'b1;
        end else if (tick && state.valid && (state.cnt != '0)) begin
            state.cnt <= state.cnt - 1'b1;
        end
    end

    assign expired = state.valid && (state.cnt == '0);

endmodule

// File: rtl/delay_event_scheduler.sv
// Timed-event scheduler: holds SLOTS delayed events and releases expired ones oldest-accepted first.
module delay_event_scheduler
    import delay_event_scheduler_pkg::*;
#(
    parameter  int SLOTS = SCHED_SLOTS,
    parameter  int DW    = SCHED_DW,
    parameter  int IW    = SCHED_IW,
    localparam int CW    = $clog2(SLOTS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic                          flush,
    delay_event_scheduler_if.slave        bus,
    output logic [CW-1:0]                 occupancy
);

    slot_t             slot_q  [SLOTS];
    logic [SLOTS-1:0]  valid_w;
    logic [SLOTS-1:0]  exp_w;
    logic [SLOTS-1:0]  load_oh;
    logic [SLOTS-1:0]  sel_oh;
    logic [SLOTS-1:0]  clear_w;
    logic [SLOTS-1:0]  older_q [SLOTS];
    logic              accept;
    logic              fire;
    slot_t             load_val;

    assign load_val = '{valid: 1'b1, cnt: bus.req_delay, id: bus.req_id};

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        delay_event_scheduler_slot u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .load     (accept && load_oh[i]),
            .clear    (clear_w[i]),
            .load_val (load_val),
            .state    (slot_q[i]),
            .expired  (exp_w[i])
        );
        assign valid_w[i] = slot_q[i].valid;
        // older_q[i][j]=1 means slot j was accepted before slot i
        assign sel_oh[i]  = exp_w[i] && ((older_q[i] & exp_w) == '0);
        assign clear_w[i] = flush || (fire && sel_oh[i]);
    end

    // lowest clear bit of valid_w; zero when every slot is taken
    assign load_oh       = ~valid_w & (valid_w + 1'b1);
    assign bus.req_ready = ~&valid_w;
    assign bus.fire_valid = |exp_w;
    assign accept        = bus.req_valid && bus.req_ready && !flush;
    assign fire          = bus.fire_valid && bus.fire_ready && !flush;

    always_comb begin
        bus.fire_id = '0;
        occupancy   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (sel_oh[i]) bus.fire_id = bus.fire_id | slot_q[i].id;
            occupancy = occupancy + CW'(valid_w[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            older_q <= '{default: '0};
        end else if (flush) begin
            older_q <= '{default: '0};
        end else if (accept) begin
            for (int k = 0; k < SLOTS; k++) begin
                for (int j = 0; j < SLOTS; j++) begin
                    if (load_oh[k]) begin
                        older_q[k][j] <= (j != k) && valid_w[j];
                    end else if (load_oh[j]) begin
                        older_q[k][j] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_delay_event_scheduler.sv
// Directed bench for delay_event_scheduler: a queue of expected fire IDs checked by a negedge monitor.
module tb_delay_event_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] occupancy;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    delay_event_scheduler_if #(.DW(8), .IW(4)) bus ();

    delay_event_scheduler #(.SLOTS(4), .DW(8), .IW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int d);
        bus.req_valid = 1'b1;
        bus.req_id    = id[3:0];
        bus.req_delay = d[7:0];
        cyc(1);
        bus.req_valid = 1'b0;
    endtask

    task automatic pop_one(input int id);
        exp_q.push_back(id[3:0]);
        bus.fire_ready = 1'b1;
        cyc(1);
        bus.fire_ready = 1'b0;
    endtask

    task automatic wait_fire(input string name, input int budget);
        int n = 0;
        while (!bus.fire_valid && n < budget) begin
            cyc(1);
            n++;
        end
        if (!bus.fire_valid) check(name, 0, 1);
    endtask

    // monitor: every completed fire handshake must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && bus.fire_valid && bus.fire_ready && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fire_unexpected actual=%0d expected=none", bus.fire_id);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (bus.fire_id != e) begin
                    errors++;
                    $display("FAIL fire_id actual=%0d expected=%0d", bus.fire_id, e);
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_id     = '0;
        bus.req_delay  = '0;
        bus.fire_ready = 1'b0;

        // reset state
        cyc(2);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_fire_valid", bus.fire_valid, 0);
        check("rst_fire_id", bus.fire_id, 0);
        check("rst_occupancy", occupancy, 0);
        rst_n = 1'b1;
        cyc(1);

        // single event, delay 3
        push(5, 3);
        check("single_occ", occupancy, 1);
        check("single_fv_e0", bus.fire_valid, 0);
        cyc(1);
        check("single_fv_e1", bus.fire_valid, 0);
        cyc(1);
        check("single_fv_e2", bus.fire_valid, 0);
        cyc(1);
        check("single_fv_e3", bus.fire_valid, 1);
        check("single_fid", bus.fire_id, 5);
        pop_one(5);
        check("single_occ_after", occupancy, 0);
        check("single_fv_after", bus.fire_valid, 0);

        // same deadline: older request wins
        push(1, 4);
        push(2, 3);
        cyc(2);
        check("order_fv_early", bus.fire_valid, 0);
        cyc(1);
        check("order_fv", bus.fire_valid, 1);
        check("order_first_id", bus.fire_id, 1);
        check("order_occ", occupancy, 2);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        bus.fire_ready = 1'b1;
        cyc(1);
        check("order_second_id", bus.fire_id, 2);
        cyc(1);
        bus.fire_ready = 1'b0;
        check("order_occ_after", occupancy, 0);
        check("order_fv_after", bus.fire_valid, 0);

        // full and stall
        for (int i = 0; i < 4; i++) push(8 + i, 10);
        check("full_req_ready", bus.req_ready, 0);
        check("full_occ", occupancy, 4);
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd12;
        bus.req_delay = 8'd0;
        cyc(3);
        check("stall_occ", occupancy, 4);
        check("stall_req_ready", bus.req_ready, 0);
        wait_fire("full_fire_timeout", 20);
        check("full_first_id", bus.fire_id, 8);
        exp_q.push_back(4'd8);
        bus.fire_ready = 1'b1;
        cyc(1);
        bus.fire_ready = 1'b0;
        check("freed_req_ready", bus.req_ready, 1);
        check("freed_occ", occupancy, 3);
        cyc(1);
        bus.req_valid = 1'b0;
        check("refill_occ", occupancy, 4);
        check("refill_req_ready", bus.req_ready, 0);
        for (int i = 9; i <= 12; i++) exp_q.push_back(i[3:0]);
        bus.fire_ready = 1'b1;
        for (int n = 0; n < 20 && occupancy != 0; n++) cyc(1);
        bus.fire_ready = 1'b0;
        check("drain_occ", occupancy, 0);

        // tick gating
        push(3, 2);
        tick = 1'b1;
        cyc(1);
        check("gate_fv_t1", bus.fire_valid, 0);
        tick = 1'b0;
        cyc(1);
        check("gate_fv_t0a", bus.fire_valid, 0);
        cyc(1);
        check("gate_fv_t0b", bus.fire_valid, 0);
        tick = 1'b1;
        cyc(1);
        check("gate_fv_t2", bus.fire_valid, 1);
        check("gate_fid", bus.fire_id, 3);
        pop_one(3);
        tick = 1'b0;
        push(6, 0);
        check("zero_delay_fv", bus.fire_valid, 1);
        check("zero_delay_fid", bus.fire_id, 6);
        pop_one(6);
        tick = 1'b1;
        check("zero_delay_occ", occupancy, 0);

        // flush overrides a pending fire handshake
        push(7, 0);
        push(4, 0);
        check("flush_pre_fv", bus.fire_valid, 1);
        check("flush_pre_occ", occupancy, 2);
        flush = 1'b1;
        bus.fire_ready = 1'b1;
        cyc(1);
        flush = 1'b0;
        check("flush_fv", bus.fire_valid, 0);
        check("flush_occ", occupancy, 0);
        check("flush_req_ready", bus.req_ready, 1);
        cyc(2);
        check("flush_fv_later", bus.fire_valid, 0);
        bus.fire_ready = 1'b0;

        // asynchronous reset mid-run
        push(1, 20);
        push(2, 20);
        push(3, 20);
        check("midrst_pre_occ", occupancy, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_fv", bus.fire_valid, 0);
        check("midrst_occ", occupancy, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        check("midrst_fid", bus.fire_id, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        check("midrst_occ_after", occupancy, 0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
